// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_ctrl
//  Purpose  : RV32I load/store unit in front of a word-addressed dmem; sub-word
//             stores via read-modify-write, fault reporting without mem access.
//  Revision : 1.0
// ============================================================================
module lsu_ctrl #(
   parameter int MEM_SIZE = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [1:0]  resp_cause,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   localparam logic [31:0] C_MEM_WORDS = 32'(MEM_SIZE);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_MERGE = 3'd2,
      S_WRITE = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] merged_q, merged_d;
   logic [2:0]  funct3_q, funct3_d;
   logic        we_q, we_d;
   logic        err_q, err_d;
   logic [1:0]  cause_q, cause_d;

   logic        w_illegal, w_misalign, w_range;
   logic [31:0] w_word_idx;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_ext;
   logic [31:0] w_merged;

   assign w_word_idx = {2'b00, addr_q[31:2]};

   // Fault checks look at the live request since they decide the accept transition.
   always_comb begin
      w_illegal = 1'b0;
      if (req_we) begin
         w_illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
      end else begin
         w_illegal = req_funct3 inside {3'b011, 3'b110, 3'b111};
      end
      w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      w_range    = {2'b00, req_addr[31:2]} >= C_MEM_WORDS;
   end

   always_comb begin
      w_byte = 8'h00;
      case (addr_q[1:0])
         2'b00:   w_byte = mem_rd[7:0];
         2'b01:   w_byte = mem_rd[15:8];
         2'b10:   w_byte = mem_rd[23:16];
         default: w_byte = mem_rd[31:24];
      endcase
      w_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];

      w_load_ext = mem_rd;
      case (funct3_q)
         3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_load_ext = {24'h000000, w_byte};
         3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
         3'b101:  w_load_ext = {16'h0000, w_half};
         default: w_load_ext = mem_rd;
      endcase

      w_merged = mem_rd;
      if (funct3_q[1:0] == 2'b00) begin
         case (addr_q[1:0])
            2'b00:   w_merged[7:0]   = wdata_q[7:0];
            2'b01:   w_merged[15:8]  = wdata_q[7:0];
            2'b10:   w_merged[23:16] = wdata_q[7:0];
            default: w_merged[31:24] = wdata_q[7:0];
         endcase
      end else if (funct3_q[1:0] == 2'b01) begin
         if (addr_q[1]) w_merged[31:16] = wdata_q[15:0];
         else           w_merged[15:0]  = wdata_q[15:0];
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      merged_d   = merged_q;
      funct3_d   = funct3_q;
      we_d       = we_q;
      err_d      = err_q;
      cause_d    = cause_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = 32'h0;
      resp_err   = 1'b0;
      resp_cause = 2'b00;
      mem_we     = 1'b0;
      mem_a      = 32'h0;
      mem_wd     = 32'h0;

      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               funct3_d = req_funct3;
               we_d     = req_we;
               rdata_d  = 32'h0;
               merged_d = 32'h0;
               err_d    = 1'b1;
               cause_d  = 2'b00;
               if (w_illegal) begin
                  cause_d = 2'b11;
                  state_d = S_RESP;
               end else if (w_misalign) begin
                  cause_d = 2'b01;
                  state_d = S_RESP;
               end else if (w_range) begin
                  cause_d = 2'b10;
                  state_d = S_RESP;
               end else begin
                  err_d = 1'b0;
                  if (!req_we)                        state_d = S_LOAD;
                  else if (req_funct3[1:0] == 2'b10) state_d = S_WRITE;
                  else                                state_d = S_MERGE;
               end
            end
         end
         S_LOAD: begin
            mem_a   = w_word_idx;
            rdata_d = w_load_ext;
            state_d = S_RESP;
         end
         S_MERGE: begin
            mem_a    = w_word_idx;
            merged_d = w_merged;
            state_d  = S_WRITE;
         end
         S_WRITE: begin
            mem_we  = we_q;
            mem_a   = w_word_idx;
            mem_wd  = (funct3_q[1:0] == 2'b10) ? wdata_q : merged_q;
            state_d = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            resp_rdata = rdata_q;
            resp_err   = err_q;
            resp_cause = cause_q;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
         merged_q <= 32'h0;
         funct3_q <= 3'b000;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         cause_q  <= 2'b00;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         merged_q <= merged_d;
         funct3_q <= funct3_d;
         we_q     <= we_d;
         err_q    <= err_d;
         cause_q  <= cause_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_ctrl
//  Purpose  : Directed scoreboard bench for lsu_ctrl with a behavioural dmem.
//  Revision : 1.0
// ============================================================================
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_cause;
   logic        mem_we;
   logic [31:0] mem_a, mem_wd, mem_rd;

   logic [31:0] dmem [64];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic [1:0]  cause;
      int          t;
      int          lat;
   } resp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   resp_t rq[$];
   wr_t   wq[$];
   resp_t re;
   wr_t   we_e;

   lsu_ctrl #(.MEM_SIZE(64)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .resp_cause (resp_cause),
      .mem_we     (mem_we),
      .mem_a      (mem_a),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign mem_rd = (mem_a < 32'd64) ? dmem[mem_a[5:0]] : 32'h0;

   always @(posedge clk) begin
      if (mem_we && (mem_a < 32'd64)) dmem[mem_a[5:0]] <= mem_wd;
   end

   // Response and write monitor: pops the scoreboard whenever the DUT presents something.
   always @(negedge clk) begin
      if (!reset) begin
         if (resp_valid) begin
            checks++;
            if (rq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_resp: got rdata=%h err=%0b cause=%0b, none expected",
                        resp_rdata, resp_err, resp_cause);
            end else begin
               re = rq.pop_front();
               if (resp_rdata !== re.rdata || resp_err !== re.err ||
                   resp_cause !== re.cause || (cyc - re.t) != re.lat) begin
                  errors++;
                  $display("FAIL resp: got rdata=%h err=%0b cause=%0b lat=%0d, expected rdata=%h err=%0b cause=%0b lat=%0d",
                           resp_rdata, resp_err, resp_cause, cyc - re.t,
                           re.rdata, re.err, re.cause, re.lat);
               end
            end
         end
         if (mem_we) begin
            checks++;
            if (wq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: got a=%h wd=%h, none expected", mem_a, mem_wd);
            end else begin
               we_e = wq.pop_front();
               if (mem_a !== we_e.a || mem_wd !== we_e.d) begin
                  errors++;
                  $display("FAIL write: got a=%h wd=%h, expected a=%h wd=%h",
                           mem_a, mem_wd, we_e.a, we_e.d);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Presents a request, waits for acceptance and records the expected response.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit exp_resp, input logic [31:0] er,
                        input logic e_err, input logic [1:0] e_cause, input int lat,
                        input int exp_wait, input bit hold);
      int    waits;
      resp_t r;
      waits = 0;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      while (!req_ready && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: req_ready still %0b after %0d cycles, expected 1", req_ready, waits);
         req_valid = 1'b0;
         return;
      end
      if (exp_wait >= 0) check("busy_cycles", waits, exp_wait);
      if (exp_resp) begin
         r.rdata = er;
         r.err   = e_err;
         r.cause = e_cause;
         r.t     = cyc;
         r.lat   = lat;
         rq.push_back(r);
      end
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
   endtask

   initial begin
      int w;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      for (int i = 0; i < 64; i++) dmem[i] = 32'h0;
      dmem[8] = 32'h00023BFF;
      dmem[9] = 32'h000239DF;

      #7;
      check("rst_req_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_err", resp_err, 0);
      check("rst_resp_cause", resp_cause, 0);
      check("rst_resp_rdata", resp_rdata, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_a", mem_a, 0);
      check("rst_mem_wd", mem_wd, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Load extraction
      issue(0, 3'b000, 32'h20, 0, 1, 32'hFFFFFFFF, 0, 2'b00, 2, -1, 0);
      issue(0, 3'b100, 32'h20, 0, 1, 32'h000000FF, 0, 2'b00, 2, -1, 0);
      issue(0, 3'b001, 32'h22, 0, 1, 32'h00000002, 0, 2'b00, 2, -1, 0);
      issue(0, 3'b010, 32'h20, 0, 1, 32'h00023BFF, 0, 2'b00, 2, -1, 0);
      issue(0, 3'b101, 32'h20, 0, 1, 32'h00003BFF, 0, 2'b00, 2, -1, 0);
      issue(0, 3'b101, 32'h22, 0, 1, 32'h00000002, 0, 2'b00, 2, -1, 0);
      issue(0, 3'b000, 32'hFF, 0, 1, 32'h00000000, 0, 2'b00, 2, -1, 0);

      // Stores
      wq.push_back('{32'd8, 32'h0002ABFF});
      issue(1, 3'b000, 32'h21, 32'h123456AB, 1, 32'h0, 0, 2'b00, 3, -1, 0);
      issue(0, 3'b010, 32'h20, 0, 1, 32'h0002ABFF, 0, 2'b00, 2, -1, 0);
      wq.push_back('{32'd9, 32'hBEEF39DF});
      issue(1, 3'b001, 32'h26, 32'h0000BEEF, 1, 32'h0, 0, 2'b00, 3, -1, 0);
      wq.push_back('{32'd10, 32'hDEADBEEF});
      issue(1, 3'b010, 32'h28, 32'hDEADBEEF, 1, 32'h0, 0, 2'b00, 2, -1, 0);
      issue(0, 3'b010, 32'h28, 0, 1, 32'hDEADBEEF, 0, 2'b00, 2, -1, 0);

      // Faults: no write expected for any of these
      issue(0, 3'b010, 32'h22, 0, 1, 32'h0, 1, 2'b01, 1, -1, 0);
      issue(0, 3'b001, 32'h101, 0, 1, 32'h0, 1, 2'b01, 1, -1, 0);
      issue(0, 3'b010, 32'h100, 0, 1, 32'h0, 1, 2'b10, 1, -1, 0);
      issue(1, 3'b100, 32'h20, 32'h55, 1, 32'h0, 1, 2'b11, 1, -1, 0);
      issue(0, 3'b011, 32'h20, 0, 1, 32'h0, 1, 2'b11, 1, -1, 0);
      issue(1, 3'b010, 32'h8000_0020, 32'h1, 1, 32'h0, 1, 2'b10, 1, -1, 0);

      // Back-to-back with req_valid held high
      issue(0, 3'b010, 32'h24, 0, 1, 32'hBEEF39DF, 0, 2'b00, 2, -1, 1);
      issue(0, 3'b001, 32'h26, 0, 1, 32'hFFFFBEEF, 0, 2'b00, 2, 2, 1);
      wq.push_back('{32'd9, 32'hBEEF3955});
      issue(1, 3'b000, 32'h24, 32'h00000055, 1, 32'h0, 0, 2'b00, 3, 2, 1);
      issue(0, 3'b010, 32'h24, 0, 1, 32'hBEEF3955, 0, 2'b00, 2, 3, 0);

      // Reset while an SB sits in WRITE: the write must never land
      wq.push_back('{32'd10, 32'hDEADBE11});
      issue(1, 3'b000, 32'h28, 32'h00000011, 0, 32'h0, 0, 2'b00, 0, -1, 0);
      w = 0;
      while (!mem_we && w < 10) begin
         @(negedge clk);
         w++;
      end
      check("sb_in_write", mem_we, 1);
      #1 reset = 1'b1;
      #1;
      check("abort_mem_we", mem_we, 0);
      check("abort_resp_valid", resp_valid, 0);
      check("abort_mem_a", mem_a, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("post_abort_ready", req_ready, 1);
      repeat (3) @(negedge clk);
      issue(0, 3'b010, 32'h28, 0, 1, 32'hDEADBEEF, 0, 2'b00, 2, -1, 0);

      w = 0;
      while ((rq.size() != 0 || wq.size() != 0) && w < 20) begin
         @(negedge clk);
         w++;
      end
      repeat (3) @(negedge clk);
      check("resp_queue_drained", rq.size(), 0);
      check("write_queue_drained", wq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store unit between the core's memory stage and the word-addressed data memory (dmem). It converts byte addresses and RV32I load/store funct3 into word-index accesses. Sub-word stores are done as read-modify-write, because dmem only writes full words. Loads are extracted and sign- or zero-extended. Misaligned, out-of-range and illegal-width requests are reported without touching memory.

Parameters:
MEM_SIZE, 64, number of 32-bit words in the attached dmem; word index >= MEM_SIZE is out of range.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  core request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I width/sign code
req_addr  input  32  byte address
req_wdata  input  32  store data (LSBs used for SB/SH)
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores and faults
resp_err  output  1  request faulted (qualified by resp_valid)
resp_cause  output  2  00 none, 01 misaligned, 10 out of range, 11 illegal funct3
mem_we  output  1  dmem write enable
mem_a  output  32  dmem word index = {2'b00, addr[31:2]}
mem_wd  output  32  dmem write data
mem_rd  input  32  dmem combinational read data for mem_a

Behaviour:
- Reset (async) puts the FSM in IDLE and zeroes all latched state. Output values during reset:
  - req_ready = 1
  - resp_valid = 0, resp_err = 0, resp_cause = 00, resp_rdata = 0
  - mem_we = 0, mem_a = 0, mem_wd = 0
- FSM states: IDLE, LOAD, MERGE, WRITE, RESP.
- IDLE, on req_valid & req_ready: latch addr, funct3, wdata and we, then evaluate faults in priority order:
  - illegal funct3 (load: 011, 110, 111; store: anything other than 000, 001, 010) → cause 11
  - misaligned (halfword with addr[0] = 1; word with addr[1:0] != 0) → cause 01
  - addr[31:2] >= MEM_SIZE → cause 10
- IDLE next state:
  - any fault → RESP with err set
  - load → LOAD
  - SW → WRITE
  - SB/SH → MERGE
- LOAD: drive mem_a. Capture mem_rd and select the byte by addr[1:0] or the halfword by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Store the result in the rdata register, then go to RESP.
- MERGE: drive mem_a. Capture mem_rd and replace the target lane with wdata[7:0] (byte lane addr[1:0]) or wdata[15:0] (half lane addr[1]). Store the merged word, then go to WRITE.
- WRITE: mem_we = 1 for exactly one cycle; mem_wd = merged word (SB/SH) or wdata (SW); mem_a = latched index. Then go to RESP.
- RESP: resp_valid = 1 for exactly one cycle with registered rdata, err and cause, then back to IDLE. A new request is not accepted in RESP.
- Outside LOAD, MERGE and WRITE: mem_we = 0, mem_a = 0, mem_wd = 0. Outside RESP: resp_* = 0.
- Latency from the accept cycle T:
  - fault: resp_valid at T+1
  - load or SW: resp_valid at T+2
  - SB/SH: resp_valid at T+3
- Throughput: one request per (latency + 1) cycles, because req_ready is high in IDLE only.
- A faulted request never asserts mem_we.
- Reset mid-operation (any state) aborts the request: no write is issued and no resp_valid is produced.
- req_valid while busy is ignored. The core must hold the request until it is accepted.
- Address upper bits are not truncated: any bit set in addr[31:2] that makes the index >= MEM_SIZE is an out-of-range fault.

Test Plan:
- After reset, with dmem word 8 = 0x00023BFF:
  - LB addr 0x20 → resp_rdata 0xFFFFFFFF at T+2
  - LBU addr 0x20 → 0x000000FF
  - LH addr 0x22 → 0x00000002
  - LW addr 0x20 → 0x00023BFF
  - LHU addr 0x20 → 0x00003BFF
- SB wdata 0x123456AB to addr 0x21 → MERGE at T+1, mem_we at T+2 with mem_a 8, mem_wd 0x0002ABFF, resp_valid at T+3. A subsequent LW 0x20 returns 0x0002ABFF.
- SH wdata 0x0000BEEF to addr 0x26 (word 9 = 0x000239DF) → mem_wd 0xBEEF39DF. SW 0xDEADBEEF to addr 0x28 → mem_we at T+1 with mem_wd 0xDEADBEEF.
- Fault requests, each → resp_valid at T+1, resp_rdata 0, mem_we never asserted:
  - LW addr 0x22 → resp_err 1, cause 01
  - LH addr 0x101 → cause 01 (misaligned outranks range)
  - LW addr 0x100 → cause 10
  - store funct3 100 → cause 11
- Back-to-back req_valid held high → req_ready low in LOAD/MERGE/WRITE/RESP; second request accepted only in the IDLE cycle after RESP; both responses correct and in order.
- Assert reset during WRITE of an SB → mem_we drops immediately, no resp_valid, FSM in IDLE, req_ready = 1 after reset deasserts.
